// File: rtl/alu_bool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bool_pkg
//  Description : Shared opcode constants and FSM state encoding for the
//                boolean ALU and its request arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_bool_pkg;

  localparam logic [3:0] OPCODE_XOR = 4'b0100;
  localparam logic [3:0] OPCODE_NOR = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the ALU implements the given opcode
  function automatic logic opcode_supported(input logic [3:0] op);
    return (op == OPCODE_XOR) || (op == OPCODE_NOR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bool_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request strictly after ptr, wrapping modulo NUM_REQ.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  // Scan from ptr+1 around the ring; the first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any       = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_bool_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bool_arbiter
//  Description : Shares one combinational alu_bool between NUM_REQ requesters.
//                Round-robin grant, operands latched and issued for one cycle,
//                result registered and returned on a valid/ready channel
//                tagged with the requester id.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_bool_arbiter
  import alu_bool_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]     req_opcode,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_opcode,
  output logic                     alu_en,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     busy
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // Outputs decode straight from state so an async reset clears them at once
  assign req_ready  = (state_q == IDLE) ? w_gnt : '0;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign alu_en     = (state_q == EXEC);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

  // Next-state, operand latch and result capture
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
              a_d  = req_a[i*WIDTH +: WIDTH];
              b_d  = req_b[i*WIDTH +: WIDTH];
              op_d = req_opcode[i*4 +: 4];
            end
          end
          id_d     = w_gnt_idx;
          rr_ptr_d = w_gnt_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // Unsupported opcodes return zero with the error flag set
        if (opcode_supported(op_q)) begin
          result_d = alu_result;
          err_d    = 1'b0;
        end else begin
          result_d = '0;
          err_d    = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; rr_ptr resets so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire
